// File: rtl/max_bus_pkg.sv
// rtl/max_bus_pkg.sv - shared state encoding and constants for the MAX bus sequencer
package max_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARN   = 2'd1,
        STEAL  = 2'd2,
        HALTED = 2'd3
    } bus_state_e;

    localparam int BA_WARN_CYCLES  = 3;
    localparam int MIN_HALF_PERIOD = 2;

endpackage

// File: rtl/max_phase_gen.sv
// rtl/max_phase_gen.sv - PHI2 phase counter with registered end-of-phase strobes
module max_phase_gen
    import max_bus_pkg::*;
#(
    parameter int HALF_PERIOD = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic phi2_o,
    output logic phi1_end_o,
    output logic phi2_end_o
);

    localparam int CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST_CNT     = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] PRE_LAST_CNT = CW'(HALF_PERIOD - 2);

    if (HALF_PERIOD < MIN_HALF_PERIOD) begin : g_bad_half_period
        $error("max_phase_gen: HALF_PERIOD must be at least MIN_HALF_PERIOD");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phi2_q, phi2_d;
    logic          phi1_end_q, phi1_end_d;
    logic          phi2_end_q, phi2_end_d;

    // Strobes are computed one cycle early so they are registered yet align with LAST_CNT.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        phi2_d = phi2_q;
        if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            phi2_d = ~phi2_q;
        end
        phi1_end_d = (cnt_q == PRE_LAST_CNT) && !phi2_q;
        phi2_end_d = (cnt_q == PRE_LAST_CNT) && phi2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            phi2_q     <= 1'b0;
            phi1_end_q <= 1'b0;
            phi2_end_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phi2_q     <= phi2_d;
            phi1_end_q <= phi1_end_d;
            phi2_end_q <= phi2_end_d;
        end
    end

    assign phi2_o     = phi2_q;
    assign phi1_end_o = phi1_end_q;
    assign phi2_end_o = phi2_end_q;

endmodule

// File: rtl/max_bus_sequencer.sv
// rtl/max_bus_sequencer.sv - MAX bus timing and BA/AEC arbitration; optional MAX_BUS_SEQ_HALT_EN adds HALT
module max_bus_sequencer
    import max_bus_pkg::*;
#(
    parameter int HALF_PERIOD = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic DMA_REQ,
`ifdef MAX_BUS_SEQ_HALT_EN
    input  logic HALT,
`endif
    output logic PHI2,
    output logic PHI1_END,
    output logic PHI2_END,
    output logic BA,
    output logic AEC
);

    localparam logic [1:0] LAST_WARN = 2'(BA_WARN_CYCLES - 1);

    bus_state_e state_q, state_d;
    logic [1:0] warn_q, warn_d;
    logic       ba_q, ba_d;
    logic       aec_q, aec_d;

    max_phase_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase_gen (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .phi2_o     (PHI2),
        .phi1_end_o (PHI1_END),
        .phi2_end_o (PHI2_END)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            warn_q  <= '0;
            ba_q    <= 1'b1;
            aec_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            warn_q  <= warn_d;
            ba_q    <= ba_d;
            aec_q   <= aec_d;
        end
    end

    // Inputs are only looked at on strobe cycles, so mid-phase changes never move the FSM.
    always_comb begin
        state_d = state_q;
        warn_d  = warn_q;
        case (state_q)
            IDLE: begin
                if (PHI1_END) begin
                    if (DMA_REQ) begin
                        state_d = WARN;
                        warn_d  = '0;
                    end
`ifdef MAX_BUS_SEQ_HALT_EN
                    else if (HALT) begin
                        state_d = HALTED;
                    end
`endif
                end
            end
            WARN: begin
                if (PHI2_END) begin
                    if (warn_q == LAST_WARN) begin
                        state_d = STEAL;
                    end else begin
                        warn_d = warn_q + 2'd1;
                    end
                end else if (PHI1_END && !DMA_REQ) begin
                    state_d = IDLE;
                end
            end
            STEAL: begin
                if (PHI1_END && !DMA_REQ) begin
                    state_d = IDLE;
                end
            end
`ifdef MAX_BUS_SEQ_HALT_EN
            HALTED: begin
                if (PHI1_END) begin
                    if (DMA_REQ) begin
                        state_d = WARN;
                        warn_d  = '0;
                    end else if (!HALT) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ba_d  = (state_d == IDLE);
        aec_d = (state_d != STEAL);
    end

    assign BA  = ba_q;
    assign AEC = aec_q;

endmodule
